// File: rtl/lc3b_lsu.sv
// lc3b_lsu: one-request-at-a-time load/store engine driving a word-wide memory port,
// with byte lanes, sign-extended byte loads and single-request indirect (LDI/STI) access.
module lc3b_lsu #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]        req_wdata,
    output logic                    resp_valid,
    output logic [WIDTH-1:0]        resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [WIDTH/8-1:0]      mem_byte_enable,
    output logic [WIDTH-1:0]        mem_wdata,
    input  logic [WIDTH-1:0]        mem_rdata,
    input  logic                    mem_resp
);
    localparam int LANES = WIDTH / 8;
    localparam int BSEL  = $clog2(LANES);
    localparam logic [2:0] OP_LDW = 3'b000;
    localparam logic [2:0] OP_LDB = 3'b001;
    localparam logic [2:0] OP_STW = 3'b010;
    localparam logic [2:0] OP_STB = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;
    localparam logic [2:0] OP_STI = 3'b101;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, PTR, DONE} state_t;

    state_t                r_state, w_next;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr, r_ptr;
    logic [BSEL-1:0]       r_lane;
    logic [WIDTH-1:0]      r_wdata, r_rdata;
    logic                  r_err;
    logic [7:0]            w_byte;
    logic                  w_indirect, w_store;

    assign w_indirect = r_op == OP_LDI || r_op == OP_STI;
    assign w_store    = r_op == OP_STW || r_op == OP_STB;
    assign w_byte     = mem_rdata[{r_lane, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && req_valid) begin
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_lane  <= req_addr[BSEL-1:0];
            r_wdata <= req_wdata;
            r_err   <= req_op[2:1] == 2'b11;
            r_rdata <= '0;
        end
        // First-phase result: pointer for indirect ops, final data otherwise
        if (r_state == ACCESS && mem_resp) begin
            r_ptr   <= ADDR_WIDTH'(mem_rdata);
            r_rdata <= r_op == OP_LDW ? mem_rdata :
                       r_op == OP_LDB ? {{(WIDTH-8){w_byte[7]}}, w_byte} : '0;
        end
        if (r_state == PTR && mem_resp) r_rdata <= r_op == OP_LDI ? mem_rdata : '0;
    end

    always_comb begin
        w_next          = r_state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_err        = 1'b0;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = req_op[2:1] == 2'b11 ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_address     = r_addr & ALIGN_MASK;
                mem_read        = !w_store;
                mem_write       = w_store;
                mem_byte_enable = r_op == OP_STW ? {LANES{1'b1}} :
                                  r_op == OP_STB ? LANES'(1) << r_lane : '0;
                mem_wdata       = r_op == OP_STB ? {LANES{r_wdata[7:0]}} :
                                  r_op == OP_STW ? r_wdata : '0;
                if (mem_resp) w_next = w_indirect ? PTR : DONE;
            end
            PTR: begin
                mem_address     = r_ptr & ALIGN_MASK;
                mem_read        = r_op == OP_LDI;
                mem_write       = r_op == OP_STI;
                mem_byte_enable = r_op == OP_STI ? {LANES{1'b1}} : '0;
                mem_wdata       = r_op == OP_STI ? r_wdata : '0;
                if (mem_resp) w_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_err   = r_err;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lc3b_lsu.sv
// tb_lc3b_lsu: randomized scoreboard bench for lc3b_lsu against a word-array memory model,
// plus a small directed run of a 32-bit instance.
module tb_lc3b_lsu;
    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
    logic        resp_valid, resp_err;
    logic [15:0] resp_rdata, mem_address, mem_wdata;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_resp = 1'b0;

    logic        req_valid32 = 1'b0;
    logic        req_ready32, resp_valid32, resp_err32, mem_read32, mem_write32;
    logic [2:0]  req_op32 = 3'b000;
    logic [15:0] req_addr32 = 16'h0, mem_address32;
    logic [31:0] req_wdata32 = 32'h0, resp_rdata32, mem_wdata32;
    logic [3:0]  mem_byte_enable32;

    logic [15:0] dut_mem [0:32767];
    logic [15:0] ref_mem [0:32767];
    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0, n_fail = 0, cyc = 0, accept_cyc = 0;
    int          n_acc = 0, n_waits = 0, acc_base = 0, wait_base = 0;
    int          fixed_wait = -1, wait_left = -1;
    bit          stall2 = 1'b0;
    logic [35:0] held_bus;
    logic [15:0] last_raddr = 16'h0, last_waddr = 16'h0, last_wdata = 16'h0;
    logic [1:0]  last_be = 2'b00;

    lc3b_lsu #(.WIDTH(16), .ADDR_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    lc3b_lsu #(.WIDTH(32), .ADDR_WIDTH(16)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid32), .req_ready(req_ready32), .req_op(req_op32),
        .req_addr(req_addr32), .req_wdata(req_wdata32), .resp_valid(resp_valid32), .resp_rdata(resp_rdata32),
        .resp_err(resp_err32), .mem_address(mem_address32), .mem_read(mem_read32), .mem_write(mem_write32),
        .mem_byte_enable(mem_byte_enable32), .mem_wdata(mem_wdata32), .mem_rdata(32'h80FF7F01), .mem_resp(1'b1)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic abort_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "run stopped after timeout");
    endtask

    // Memory responder: zero or more wait states per access, spurious mem_resp while idle
    initial forever begin
        @(negedge clk);
        mem_resp = 1'b0;
        if (mem_read !== 1'b1 && mem_write !== 1'b1) begin
            wait_left = -1;
            if ($urandom_range(0, 3) == 0) begin
                mem_resp  = 1'b1;
                mem_rdata = 16'($urandom);
            end
        end else begin
            check("strobe_excl", 64'(mem_read & mem_write), 64'(0));
            if (wait_left < 0) begin
                n_acc++;
                held_bus = {mem_address, mem_wdata, mem_byte_enable, mem_read, mem_write};
                check("addr_align", 64'(mem_address[0]), 64'(0));
                check("read_be", mem_read ? 64'(mem_byte_enable) : 64'(0), 64'(0));
                wait_left = (stall2 && n_acc - acc_base == 2) ? 1000 :
                            (fixed_wait >= 0 ? fixed_wait : int'($urandom_range(0, 3)));
            end else begin
                check("hold_stable", 64'({mem_address, mem_wdata, mem_byte_enable, mem_read, mem_write}),
                      64'(held_bus));
            end
            if (wait_left == 0) begin
                mem_resp  = 1'b1;
                wait_left = -1;
                if (mem_read) begin
                    mem_rdata  = dut_mem[mem_address[15:1]];
                    last_raddr = mem_address;
                end else begin
                    if (mem_byte_enable[0]) dut_mem[mem_address[15:1]][7:0]  = mem_wdata[7:0];
                    if (mem_byte_enable[1]) dut_mem[mem_address[15:1]][15:8] = mem_wdata[15:8];
                    last_waddr = mem_address;
                    last_wdata = mem_wdata;
                    last_be    = mem_byte_enable;
                end
            end else begin
                wait_left--;
                n_waits++;
            end
        end
    end

    // Monitor: pops one expectation per response pulse
    initial forever begin
        @(negedge clk);
        if (rst !== 1'b1 && cyc > 0) begin
            if (resp_valid === 1'b1) begin
                if (sb.size() == 0) check("resp_unexpected", 64'(resp_valid), 64'(0));
                else begin
                    mon_e = sb.pop_front();
                    check("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
                    check("resp_err", 64'(resp_err), 64'(mon_e.err));
                    check("latency", 64'(cyc - accept_cyc + 1), 64'(mon_e.lat + n_waits - wait_base));
                    check("access_count", 64'(n_acc - acc_base), 64'(mon_e.acc));
                    check("ready_in_done", 64'(req_ready), 64'(0));
                end
            end else check("idle_resp_zero", 64'({resp_rdata, resp_err}), 64'(0));
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        dut_mem[a >> 1] = v;
        ref_mem[a >> 1] = v;
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wdata);
        int k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", 64'(req_ready), 64'(1));
        if (req_ready !== 1'b1) abort_run();
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wdata;
        accept_cyc = cyc + 1;
        acc_base   = n_acc;
        wait_base  = n_waits;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
    endtask

    // Reference model: memory as an array of words, bytes picked by address parity
    task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wdata);
        exp_t        e;
        logic [15:0] p;
        logic [7:0]  b;
        int          k = 0;
        e.rdata = 16'h0;
        e.err   = 1'b0;
        e.lat   = 2;
        e.acc   = 1;
        case (op)
            3'd0: e.rdata = ref_mem[addr >> 1];
            3'd1: begin
                p = ref_mem[addr >> 1];
                b = addr[0] ? p[15:8] : p[7:0];
                e.rdata = 16'($signed(b));
            end
            3'd2: ref_mem[addr >> 1] = wdata;
            3'd3: if (addr[0]) ref_mem[addr >> 1][15:8] = wdata[7:0];
                  else         ref_mem[addr >> 1][7:0]  = wdata[7:0];
            3'd4: begin
                p = ref_mem[addr >> 1];
                e.rdata = ref_mem[p >> 1];
                e.lat = 3;
                e.acc = 2;
            end
            3'd5: begin
                p = ref_mem[addr >> 1];
                ref_mem[p >> 1] = wdata;
                e.lat = 3;
                e.acc = 2;
            end
            default: begin
                e.err = 1'b1;
                e.lat = 1;
                e.acc = 0;
            end
        endcase
        sb.push_back(e);
        send(op, addr, wdata);
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("resp_timeout", 64'(sb.size()), 64'(0));
        if (sb.size() != 0) abort_run();
    endtask

    task automatic op32(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        req_valid32 = 1'b1;
        req_op32    = op;
        req_addr32  = addr;
        req_wdata32 = wdata;
        @(negedge clk);
        req_valid32 = 1'b0;
        check("w32_addr", 64'(mem_address32), 64'(addr & 16'hFFFC));
        check("w32_be", 64'(mem_byte_enable32), 64'(exp_be));
        check("w32_strobes", 64'({mem_read32, mem_write32}), 64'(op[1] ? 2'b01 : 2'b10));
        if (op[1]) check("w32_wdata", 64'(mem_wdata32), 64'(exp_wdata));
        @(negedge clk);
        check("w32_resp", 64'({resp_valid32, resp_err32, req_ready32}), 64'(3'b100));
        check("w32_rdata", 64'(resp_rdata32), 64'(exp_rdata));
        @(negedge clk);
    endtask

    initial begin
        int nd = 0;
        int k = 0;
        for (int i = 0; i < 32768; i++) begin
            logic [15:0] v = 16'($urandom);
            if (i >= 128 && i < 160 && v[15]) v = {10'h040, v[5:0]};
            dut_mem[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'(1));
        check("rst_outputs", 64'({resp_valid, resp_rdata, resp_err, mem_address, mem_read, mem_write,
                                  mem_byte_enable, mem_wdata}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        fixed_wait = 0;
        preload(16'h3004, 16'hBEEF);
        issue(3'd0, 16'h3005, 16'h0);
        check("ldw_addr", 64'(last_raddr), 64'(16'h3004));

        fixed_wait = 2;
        preload(16'h2000, 16'h807F);
        issue(3'd1, 16'h2001, 16'h0);
        issue(3'd1, 16'h2000, 16'h0);

        fixed_wait = 1;
        issue(3'd3, 16'h1003, 16'h12A5);
        check("stb_wdata", 64'(last_wdata), 64'(16'hA5A5));
        check("stb_be", 64'(last_be), 64'(2'b10));
        check("stb_addr", 64'(last_waddr), 64'(16'h1002));

        fixed_wait = 0;
        preload(16'h4000, 16'h6003);
        preload(16'h6002, 16'h1234);
        issue(3'd4, 16'h4000, 16'h0);
        check("ldi_ptr_addr", 64'(last_raddr), 64'(16'h6002));
        preload(16'h4000, 16'h6000);
        issue(3'd5, 16'h4000, 16'hCAFE);
        check("sti_write", 64'({last_waddr, last_wdata, last_be}), 64'({16'h6000, 16'hCAFE, 2'b11}));

        issue(3'd6, 16'h1234, 16'h5555);
        issue(3'd7, 16'h0101, 16'hAAAA);

        // Reset while the pointer phase is stalled
        preload(16'h4000, 16'h6003);
        stall2 = 1'b1;
        send(3'd4, 16'h4000, 16'h0);
        while (n_acc - acc_base < 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ptr_reached", 64'(n_acc - acc_base), 64'(2));
        check("ptr_phase", 64'({mem_read, mem_write, mem_address}), 64'({2'b10, 16'h6002}));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_idle", 64'({req_ready, resp_valid, mem_read, mem_write, mem_byte_enable}),
              64'(6'b100000));
        rst = 1'b0;
        stall2 = 1'b0;
        repeat (3) @(negedge clk);
        issue(3'd0, 16'h3005, 16'h0);

        fixed_wait = -1;
        for (int i = 0; i < 300; i++) begin
            int r = int'($urandom_range(0, 15));
            issue(r < 14 ? 3'(r % 6) : 3'(r - 8), {10'h040, 6'($urandom)}, 16'($urandom));
        end

        for (int i = 0; i < 32768; i++) if (dut_mem[i] !== ref_mem[i]) nd++;
        check("mem_final", 64'(nd), 64'(0));

        op32(3'd3, 16'h0103, 32'h1234565A, 32'h0, 4'b1000, 32'h5A5A5A5A);
        op32(3'd3, 16'h0100, 32'h000000C3, 32'h0, 4'b0001, 32'hC3C3C3C3);
        op32(3'd2, 16'h0102, 32'hDEADBEEF, 32'h0, 4'b1111, 32'hDEADBEEF);
        op32(3'd1, 16'h0103, 32'h0, 32'hFFFFFF80, 4'b0000, 32'h0);
        op32(3'd1, 16'h0102, 32'h0, 32'hFFFFFFFF, 4'b0000, 32'h0);
        op32(3'd1, 16'h0101, 32'h0, 32'h0000007F, 4'b0000, 32'h0);
        op32(3'd0, 16'h0107, 32'h0, 32'h80FF7F01, 4'b0000, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        abort_run();
    end
endmodule
